param_data_fifo: RTL
====================

// Module: param_data_fifo
// PURPOSE
//   Parametrised first-word-fall-through circular buffer with valid/ready on both sides.
//   Adds full/empty flow control, occupancy count and sticky overflow/underflow error flags.
//   Sits between a byte/word producer and a consumer in medium-complexity datapaths.
//   Replaces fixed 4x8 buffers that have a single write pointer.
// PARAMETERS
//   DATA_W    8     data word width in bits (>=1)
//   DEPTH     4     number of entries; power of two, >=2
//   MATCH_LO  8'd0  lower bound of match range (width DATA_W), used only with the match feature
//   MATCH_HI  8'd1  upper bound of match range (width DATA_W), MATCH_LO <= MATCH_HI
//   localparam AW = $clog2(DEPTH)
// PORTS
//   clk        in   1         rising-edge clock
//   rst        in   1         asynchronous, active-high reset
//   wr_valid   in   1         producer presents wr_data
//   wr_ready   out  1         buffer can accept a word (= !full)
//   wr_data    in   DATA_W    write data
//   rd_valid   out  1         head word available (= !empty)
//   rd_ready   in   1         consumer takes head word
//   rd_data    out  DATA_W    head word; 0 when empty
//   count      out  AW+1      occupancy, 0..DEPTH
//   overflow   out  1         sticky: write attempted while full
//   underflow  out  1         sticky: read attempted while empty
//   clr_err    in   1         synchronous clear of overflow/underflow
//   match      out  1         head word within [MATCH_LO:MATCH_HI] (see CONFIGURATION)
// BEHAVIOUR
//   - Reset: wr_ptr=0, rd_ptr=0, count=0, overflow=0, underflow=0; storage not reset.
//     Outputs after reset: wr_ready=1, rd_valid=0, rd_data=0, match=0.
//   - Write fires when wr_valid && wr_ready: mem[wr_ptr]<=wr_data; wr_ptr<=wr_ptr+1 (mod DEPTH).
//   - Read fires when rd_valid && rd_ready: rd_ptr<=rd_ptr+1 (mod DEPTH).
//   - rd_data = mem[rd_ptr] combinationally (FWFT). Zero read latency.
//   - Write-to-read latency is 1 cycle: a word written at edge N is visible on rd_data after edge N.
//   - Occupancy status (data_fifo_pkg::fifo_state_t) is derived from count: EMPTY (0),
//     PARTIAL (1..DEPTH-1), FULL (DEPTH).
//   - Count update per edge: +1 on write only, -1 on read only, unchanged on both or neither.
//   - Simultaneous read and write:
//     - PARTIAL: both fire; count is unchanged.
//     - FULL: only the read fires, because wr_ready=0. No pass-through.
//     - EMPTY: only the write fires, because rd_valid=0. No bypass.
//   - Overflow: wr_valid && !wr_ready sets overflow; the data is dropped.
//   - Underflow: rd_ready && !rd_valid sets underflow.
//   - clr_err clears both flags. A set event in the same cycle wins over clr_err.
//   - Pointers wrap naturally at AW bits. count never exceeds DEPTH or goes below 0.
//   - Reset asserted mid-operation empties the buffer immediately (asynchronously);
//     contents are discarded.
// CONFIGURATION
//   Macro DATA_FIFO_MATCH_EN:
//   - Defined: match = rd_valid && (rd_data inside {[MATCH_LO:MATCH_HI]}), combinational.
//   - Undefined: match is tied to 1'b0. No comparator logic is synthesised.
//     The port list is identical in both cases.
// STRUCTURE
//   - Package data_fifo_pkg:
//     - typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} fifo_state_t
//     - function fifo_state_f(count, depth) returning fifo_state_t
//   - Sub-module data_fifo_mem: DEPTH x DATA_W storage, one synchronous write port,
//     one asynchronous read port, no reset.
//   - The top level holds pointers, count, flags and the match logic.
// TESTING (DATA_W=8, DEPTH=4)
//   1. Reset, then write 8'h11,8'h22,8'h33,8'h44 -> count=4, wr_ready=0, rd_data=8'h11.
//      Then read 4 words -> rd_data 11,22,33,44 in order; count=0, rd_valid=0, rd_data=0.
//   2. Full, then wr_valid with 8'h55 -> overflow=1, 8'h55 never read.
//      Then clr_err -> overflow=0 next cycle.
//   3. Empty, then rd_ready=1 -> underflow=1.
//      Same cycle as clr_err with a new underflow -> underflow stays 1.
//   4. count=2 with simultaneous write and read for 10 cycles -> count stays 2,
//      data in order, pointers wrap.
//   5. Write 3 words, then assert rst mid-stream -> count=0, rd_valid=0 and wr_ready=1
//      before the next edge.
//   6. With DATA_FIFO_MATCH_EN, MATCH_LO=8'd10, MATCH_HI=8'd20:
//      head 8'd10 -> match=1; head 8'd21 -> match=0; empty -> match=0.
//      Without the macro -> match=0 always.

Source files
------------

// File: rtl/data_fifo_pkg.sv
// Shared types and helpers for the param_data_fifo slice.
// Occupancy status is a pure function of the count so that every user
// (RTL, checkers) derives EMPTY/PARTIAL/FULL the same way.
package data_fifo_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_PARTIAL,
      ST_FULL
   } fifo_state_t;

   // Map an occupancy count onto the three-way status.
   function automatic fifo_state_t fifo_state_f(input int count, input int depth);
      if (count == 0) begin
         return ST_EMPTY;
      end
      if (count >= depth) begin
         return ST_FULL;
      end
      return ST_PARTIAL;
   endfunction

endpackage

// File: rtl/data_fifo_mem.sv
// DEPTH x DATA_W storage for param_data_fifo: one synchronous write port,
// one asynchronous (combinational) read port. Contents are never reset;
// the pointer logic in the top level decides which entries are meaningful.
module data_fifo_mem
   import data_fifo_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // Store the incoming word at the write address when the write fires.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/param_data_fifo.sv
// Parametrised first-word-fall-through circular buffer.
// Holds the read/write pointers, the occupancy count, the sticky
// overflow/underflow flags and the optional head-word range match.
// Optional feature macro: DATA_FIFO_MATCH_EN (range comparator on the head
// word; when undefined, match is tied low and no comparator exists).
//
// Handshake: a transfer happens on a rising edge exactly when valid and ready
// are both high on that side; ready (wr_ready) and valid (rd_valid) depend
// only on registered occupancy, never on the partner's valid/ready, so
// there are no combinational loops through the buffer.
module param_data_fifo
   import data_fifo_pkg::*;
#(
   parameter int                DATA_W   = 8,
   parameter int                DEPTH    = 4,
   parameter logic [DATA_W-1:0] MATCH_LO = '0,
   parameter logic [DATA_W-1:0] MATCH_HI = DATA_W'(1),
   localparam int               AW       = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic [AW:0]       count,
   output logic              overflow,
   output logic              underflow,
   input  logic              clr_err,
   output logic              match
);

   // Configuration sanity checks, evaluated at elaboration only.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("param_data_fifo: DEPTH must be a power of two and at least 2");
   end
   if (MATCH_LO > MATCH_HI) begin : g_bad_match_range
      $error("param_data_fifo: MATCH_LO must not exceed MATCH_HI");
   end

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   fifo_state_t       fifo_state;
   logic              wr_fire;
   logic              rd_fire;
   logic [DATA_W-1:0] mem_rd_data;

   assign fifo_state = fifo_state_f(32'(count_q), DEPTH);
   assign wr_ready   = (fifo_state != ST_FULL);
   assign rd_valid   = (fifo_state != ST_EMPTY);
   assign wr_fire    = wr_valid && wr_ready;
   assign rd_fire    = rd_valid && rd_ready;

   data_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_fire),
      .wr_addr (wr_ptr_q),
      .wr_data (wr_data),
      .rd_addr (rd_ptr_q),
      .rd_data (mem_rd_data)
   );

   // Stale storage must never leak out when the buffer is empty.
   assign rd_data = rd_valid ? mem_rd_data : '0;

   // Next pointers, count and sticky flags; a set event beats clr_err.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (wr_fire) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (rd_fire) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end

      case ({wr_fire, rd_fire})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      if (clr_err) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end
      if (wr_valid && !wr_ready) begin
         overflow_d = 1'b1;
      end
      if (rd_ready && !rd_valid) begin
         underflow_d = 1'b1;
      end
   end

   // Control state register; reset empties the buffer immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign count     = count_q;
   assign overflow  = overflow_q;
   assign underflow = underflow_q;

`ifdef DATA_FIFO_MATCH_EN
   assign match = rd_valid && (rd_data inside {[MATCH_LO:MATCH_HI]});
`else
   assign match = 1'b0;
`endif

endmodule
